ex_int_unit: RTL



---
 rtl/ex_int_unit.sv | 229 ++++++++++++++++++++++
 1 files changed

// File: rtl/ex_int_unit.sv
// ex_int_unit: integer execution unit that sits after the ID/EX register.
//
// An issue is signalled by a level change on in_ce. The unit keeps only the
// issues addressed to UNIT_ID and queues them in a small FIFO. It takes one
// entry at a time and either computes a single-cycle ALU result or runs an
// iterative shift-add multiply. The result goes out on the result bus with
// its tag and target, and stays there until cdb_grant accepts it.
//
// Ports:
//   clk, rst     clock and asynchronous active-high reset
//   in_unit      execution unit the issued op is addressed to
//   in_val1/2    operands A and B
//   in_tag       reservation tag of the op
//   in_op        opcode: ADD, SUB, AND, OR, XOR, SLL, SRL, MUL; 8-15 give 0
//   in_target    destination target
//   in_ce        issue strobe; every level change is one new request
//   cdb_valid    a result is being presented
//   cdb_tag      tag of the presented result
//   cdb_target   destination of the presented result
//   cdb_data     value of the presented result
//   cdb_grant    the result bus takes the result this cycle
//   busy         request FIFO is full
//   overflow     sticky flag: a request was dropped because the FIFO was full
module ex_int_unit #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TAG_W   = 4,
  parameter int unsigned OP_W    = 4,
  parameter int unsigned TGT_W   = 5,
  parameter int unsigned UNIT_W  = 2,
  parameter int unsigned UNIT_ID = 0,
  parameter int unsigned DEPTH   = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [UNIT_W-1:0] in_unit,
  input  logic [DATA_W-1:0] in_val1,
  input  logic [DATA_W-1:0] in_val2,
  input  logic [TAG_W-1:0]  in_tag,
  input  logic [OP_W-1:0]   in_op,
  input  logic [TGT_W-1:0]  in_target,
  input  logic              in_ce,
  output logic              cdb_valid,
  output logic [TAG_W-1:0]  cdb_tag,
  output logic [TGT_W-1:0]  cdb_target,
  output logic [DATA_W-1:0] cdb_data,
  input  logic              cdb_grant,
  output logic              busy,
  output logic              overflow
);

  localparam int unsigned SHW    = $clog2(DATA_W);
  localparam int unsigned PTR_W  = $clog2(DEPTH);
  localparam int unsigned FCNT_W = PTR_W + 1;
  localparam int unsigned CNT_W  = $clog2(DATA_W) + 1;

  localparam logic [OP_W-1:0] OP_ADD = OP_W'(0);
  localparam logic [OP_W-1:0] OP_SUB = OP_W'(1);
  localparam logic [OP_W-1:0] OP_AND = OP_W'(2);
  localparam logic [OP_W-1:0] OP_OR  = OP_W'(3);
  localparam logic [OP_W-1:0] OP_XOR = OP_W'(4);
  localparam logic [OP_W-1:0] OP_SLL = OP_W'(5);
  localparam logic [OP_W-1:0] OP_SRL = OP_W'(6);
  localparam logic [OP_W-1:0] OP_MUL = OP_W'(7);

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

  // Request detection and FIFO bookkeeping
  logic              ce_q;
  logic [PTR_W-1:0]  wrPtr_q, wrPtr_d;
  logic [PTR_W-1:0]  rdPtr_q, rdPtr_d;
  logic [FCNT_W-1:0] count_q, count_d;
  logic              overflow_q, overflow_d;

  // FIFO storage
  logic [DATA_W-1:0] fifoVal1_q   [DEPTH];
  logic [DATA_W-1:0] fifoVal2_q   [DEPTH];
  logic [TAG_W-1:0]  fifoTag_q    [DEPTH];
  logic [OP_W-1:0]   fifoOp_q     [DEPTH];
  logic [TGT_W-1:0]  fifoTarget_q [DEPTH];

  // Execution state and registered result bus
  state_t            state_q;
  logic [DATA_W-1:0] mcand_q, mplier_q, acc_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              cdbValid_q;
  logic [TAG_W-1:0]  cdbTag_q;
  logic [TGT_W-1:0]  cdbTarget_q;
  logic [DATA_W-1:0] cdbData_q;

  logic              reqNew, push, pop, full, pushOk;
  logic [DATA_W-1:0] headVal1, headVal2, aluRes;
  logic [TAG_W-1:0]  headTag;
  logic [OP_W-1:0]   headOp;
  logic [TGT_W-1:0]  headTarget;

  assign reqNew = (in_ce != ce_q);
  assign push   = reqNew && (in_unit == UNIT_W'(UNIT_ID));
  assign full   = (count_q == FCNT_W'(DEPTH));
  assign pop    = (state_q == IDLE) && (count_q != '0);
  // A full FIFO can still take a push when an entry leaves in the same cycle
  assign pushOk = push && (!full || pop);

  assign headVal1   = fifoVal1_q[rdPtr_q];
  assign headVal2   = fifoVal2_q[rdPtr_q];
  assign headTag    = fifoTag_q[rdPtr_q];
  assign headOp     = fifoOp_q[rdPtr_q];
  assign headTarget = fifoTarget_q[rdPtr_q];

  always_comb begin
    wrPtr_d    = wrPtr_q;
    rdPtr_d    = rdPtr_q;
    count_d    = count_q;
    overflow_d = overflow_q | (push & full & ~pop);
    if (pushOk) wrPtr_d = wrPtr_q + PTR_W'(1);
    if (pop)    rdPtr_d = rdPtr_q + PTR_W'(1);
    case ({pushOk, pop})
      2'b10:   count_d = count_q + FCNT_W'(1);
      2'b01:   count_d = count_q - FCNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ce_q       <= 1'b0;
      wrPtr_q    <= '0;
      rdPtr_q    <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      ce_q       <= in_ce;
      wrPtr_q    <= wrPtr_d;
      rdPtr_q    <= rdPtr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage does not need a reset because the pointers and count decide
  // which entries are valid.
  always_ff @(posedge clk) begin
    if (pushOk) begin
      fifoVal1_q[wrPtr_q]   <= in_val1;
      fifoVal2_q[wrPtr_q]   <= in_val2;
      fifoTag_q[wrPtr_q]    <= in_tag;
      fifoOp_q[wrPtr_q]     <= in_op;
      fifoTarget_q[wrPtr_q] <= in_target;
    end
  end

  // Single-cycle ALU result for the FIFO head. MUL and opcodes 8-15 give 0 here.
  always_comb begin
    aluRes = '0;
    case (headOp)
      OP_ADD:  aluRes = headVal1 + headVal2;
      OP_SUB:  aluRes = headVal1 - headVal2;
      OP_AND:  aluRes = headVal1 & headVal2;
      OP_OR:   aluRes = headVal1 | headVal2;
      OP_XOR:  aluRes = headVal1 ^ headVal2;
      OP_SLL:  aluRes = headVal1 << headVal2[SHW-1:0];
      OP_SRL:  aluRes = headVal1 >> headVal2[SHW-1:0];
      default: aluRes = '0;
    endcase
  end

  // Execution FSM. EXEC runs DATA_W shift-add steps. It then takes one more
  // cycle to move the accumulator into the result register, so a multiply
  // shows cdb_valid DATA_W+1 cycles after its pop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      mcand_q     <= '0;
      mplier_q    <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
      cdbValid_q  <= 1'b0;
      cdbTag_q    <= '0;
      cdbTarget_q <= '0;
      cdbData_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (pop) begin
            cdbTag_q    <= headTag;
            cdbTarget_q <= headTarget;
            if (headOp == OP_MUL) begin
              mcand_q  <= headVal1;
              mplier_q <= headVal2;
              acc_q    <= '0;
              cnt_q    <= '0;
              state_q  <= EXEC;
            end else begin
              cdbData_q  <= aluRes;
              cdbValid_q <= 1'b1;
              state_q    <= DONE;
            end
          end
        end
        EXEC: begin
          if (cnt_q == CNT_W'(DATA_W)) begin
            cdbData_q  <= acc_q;
            cdbValid_q <= 1'b1;
            state_q    <= DONE;
          end else begin
            if (mplier_q[0]) acc_q <= acc_q + mcand_q;
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            cnt_q    <= cnt_q + CNT_W'(1);
          end
        end
        DONE: begin
          if (cdb_grant) begin
            cdbValid_q <= 1'b0;
            state_q    <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign cdb_valid  = cdbValid_q;
  assign cdb_tag    = cdbTag_q;
  assign cdb_target = cdbTarget_q;
  assign cdb_data   = cdbData_q;
  assign busy       = full;
  assign overflow   = overflow_q;

endmodule
